ncc_result_tx: RTL and testbench

Transmit side of the NCC host byte link: accepts match results (score plus window coordinates) from the correlation datapath, buffers them in a small FIFO, and serializes each into a fixed 10-byte frame on the 8-bit host output stream. It sits between the NCC scoring core and the PCI byte interface, mirroring the byte-wide descriptor load path in the opposite direction.

---
 rtl/ncc_pkg.sv | 17 +
 rtl/result_fifo.sv | 33 +++
 rtl/ncc_result_tx.sv | 108 ++++++++++
 tb/tb_ncc_result_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
// ncc_pkg: shared constants, FSM states and record layout for the NCC host byte link
package ncc_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_PAYLOAD_BYTES = 8;
    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHECK} state_t;
    typedef struct packed {
        logic [31:0] score;
        logic [15:0] x;
        logic [15:0] y;
    } rec_t;
    // Payload byte idx of a record, MSB-first across score, x, y
    function automatic logic [7:0] payload_byte(input rec_t r, input logic [2:0] idx);
        logic [63:0] w;
        w = 64'(r) << {idx, 3'b000};
        return w[63:56];
    endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with wrap-bit pointers to tell full from empty
module result_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  r_wp, r_rp;
    logic [W-1:0] r_mem [DEPTH];
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_dout  = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push && !o_full) r_wp <= r_wp + 1'b1;
            if (i_pop && !o_empty) r_rp <= r_rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !o_full) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/ncc_result_tx.sv
// ncc_result_tx: buffers match results and serializes each into a 10-byte
// frame (sync, score, x, y, XOR checksum) on the host byte stream
module ncc_result_tx
    import ncc_pkg::*;
#(
    parameter int SCORE_W    = 32,
    parameter int COORD_W    = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               resValid,
    output logic               resReady,
    input  logic [SCORE_W-1:0] resScore,
    input  logic [COORD_W-1:0] resX,
    input  logic [COORD_W-1:0] resY,
    output logic [7:0]         pciOut,
    output logic               pciValid,
    input  logic               pciReady,
    output logic [15:0]        txCount,
    output logic               busy
);
    logic       w_full, w_empty, w_push, w_pop, w_xfer, w_done;
    rec_t       w_din, w_dout, r_rec, w_rec_nxt;
    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [7:0] r_chk, w_chk_nxt, r_out, w_out_nxt;
    logic       r_valid;
    logic [15:0] r_tx_cnt;

    assign w_din    = {32'(resScore), 16'(resX), 16'(resY)};
    assign w_push   = resValid && !w_full;
    assign w_xfer   = r_valid && pciReady;
    assign resReady = !w_full;
    assign pciOut   = r_out;
    assign pciValid = r_valid;
    assign txCount  = r_tx_cnt;
    assign busy     = (r_state != IDLE) || !w_empty;

    result_fifo #(.W($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rec_nxt   = r_rec;
        w_idx_nxt   = r_idx;
        w_chk_nxt   = r_chk;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = SYNC;
            end
            SYNC: if (w_xfer) begin
                w_state_nxt = PAYLOAD;
                w_idx_nxt   = '0;
            end
            PAYLOAD: if (w_xfer) begin
                w_chk_nxt   = r_chk ^ payload_byte(r_rec, r_idx);
                w_idx_nxt   = r_idx + 1'b1;
                w_state_nxt = (r_idx == 3'(FRAME_PAYLOAD_BYTES - 1)) ? CHECK : PAYLOAD;
            end
            CHECK: if (w_xfer) begin
                w_done      = 1'b1;
                w_pop       = !w_empty;
                w_state_nxt = w_empty ? IDLE : SYNC;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_pop) begin
            w_rec_nxt = w_dout;
            w_chk_nxt = '0;
        end
        // Output byte is registered, so select it from the next-cycle state
        w_out_nxt = (w_state_nxt == SYNC)    ? SYNC_BYTE :
                    (w_state_nxt == PAYLOAD) ? payload_byte(w_rec_nxt, w_idx_nxt) :
                    (w_state_nxt == CHECK)   ? w_chk_nxt : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rec    <= '0;
            r_idx    <= '0;
            r_chk    <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_tx_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rec   <= w_rec_nxt;
            r_idx   <= w_idx_nxt;
            r_chk   <= w_chk_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_state_nxt != IDLE;
            if (w_done) r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ncc_result_tx.sv
// tb_ncc_result_tx: table-driven and randomized check of ncc_result_tx against
// a queue-based frame model
module tb_ncc_result_tx;
    logic        clk = 0, rst = 1, resValid = 0, pciReady = 0;
    logic [31:0] resScore = 0;
    logic [9:0]  resX = 0, resY = 0;
    logic        resReady, pciValid, busy;
    logic [7:0]  pciOut;
    logic [15:0] txCount;

    int          errors = 0, checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          fpos = 0;
    logic [15:0] exp_tx = 0;
    int          mode = 0, tcnt = 0;
    logic        prev_stall = 0;
    logic [7:0]  prev_out = 0;

    typedef struct {
        logic [31:0] s;
        logic [9:0]  x;
        logic [9:0]  y;
        int          m;
        logic [7:0]  want_chk;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    ncc_result_tx #(.SCORE_W(32), .COORD_W(10), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .resValid (resValid),
        .resReady (resReady),
        .resScore (resScore),
        .resX     (resX),
        .resY     (resY),
        .pciOut   (pciOut),
        .pciValid (pciValid),
        .pciReady (pciReady),
        .txCount  (txCount),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Frame model: sync, 4 score bytes, 2+2 coordinate bytes, XOR of the eight
    function automatic void add_frame(input logic [31:0] s, input logic [9:0] x, input logic [9:0] y);
        logic [7:0] b[8];
        logic [7:0] c;
        c = 8'h00;
        b = '{s[31:24], s[23:16], s[15:8], s[7:0], {6'b0, x[9:8]}, x[7:0], {6'b0, y[9:8]}, y[7:0]};
        exp_q.push_back(8'hA5);
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            c ^= b[i];
        end
        exp_q.push_back(c);
    endfunction

    task automatic push(input logic [31:0] s, input logic [9:0] x, input logic [9:0] y);
        int n = 0;
        @(negedge clk);
        resValid = 1; resScore = s; resX = x; resY = y;
        while (!resReady && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (resReady) add_frame(s, x, y);
        else chk("push_timeout", resReady, 1);
        @(negedge clk);
        resValid = 0;
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #2 mode = m;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_txcount"}, txCount, exp_tx);
    endtask

    // Host side: drives pciReady, checks hold-while-stalled and every transferred byte
    initial forever begin
        @(negedge clk);
        pciReady = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 :
                   (mode == 2) ? (tcnt % 3 == 0) : ($urandom_range(0, 1) == 1);
        tcnt++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", pciValid, 1);
                chk("hold_byte", pciOut, prev_out);
            end
            if (pciValid && pciReady) begin
                got_q.push_back(pciOut);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", pciOut);
                end else begin
                    chk("frame_byte", pciOut, exp_q.pop_front());
                end
                fpos = (fpos == 9) ? 0 : fpos + 1;
                if (fpos == 0) exp_tx++;
            end
            prev_stall = pciValid && !pciReady;
            prev_out   = pciOut;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] tx0;
        tbl[0] = '{32'h01020304, 10'd5,   10'd6,   2, 8'h07};
        tbl[1] = '{32'hFFFFFFFF, 10'h3FF, 10'h3FF, 1, 8'h00};
        tbl[2] = '{32'h00000000, 10'h000, 10'h000, 3, 8'h00};
        tbl[3] = '{32'h12345678, 10'h123, 10'h2AB, 2, 8'h83};
        tbl[4] = '{32'h80000001, 10'h200, 10'h001, 1, 8'h82};

        repeat (3) @(negedge clk);
        chk("rst_valid", pciValid, 0);
        chk("rst_out", pciOut, 0);
        chk("rst_tx", txCount, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_ready", resReady, 1);

        set_mode(1);
        push(32'h01020304, 10'd5, 10'd6);
        chk("lat_valid0", pciValid, 0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_valid1", pciValid, 1);
        chk("lat_sync", pciOut, 8'hA5);
        wait_idle("single");

        foreach (tbl[i]) begin
            set_mode(tbl[i].m);
            got_q.delete();
            push(tbl[i].s, tbl[i].x, tbl[i].y);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_len", i), got_q.size(), 10);
            chk($sformatf("vec%0d_sync", i), got_q[0], 8'hA5);
            chk($sformatf("vec%0d_cksum", i), got_q[9], tbl[i].want_chk);
        end

        // Fill: one record sits in the record register, eight fill the FIFO
        set_mode(0);
        for (int i = 0; i < 9; i++) push(32'(32'h1000 + i), 10'(i), 10'(3 * i));
        chk("fill_ready_low", resReady, 0);
        chk("fill_valid", pciValid, 1);
        chk("fill_sync", pciOut, 8'hA5);
        tx0 = txCount;
        set_mode(1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        chk("fill_cycles", n, 91);
        chk("fill_nine", 16'(txCount - tx0), 9);
        chk("fill_drain", exp_q.size(), 0);
        chk("fill_ready_back", resReady, 1);

        set_mode(3);
        for (int i = 0; i < 20; i++) begin
            push($urandom, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("random");

        // Reset after the 4th byte with a second record still queued
        set_mode(1);
        push(32'hDEADBEEF, 10'h155, 10'h2AA);
        push(32'hCAFEF00D, 10'd1, 10'd2);
        n = 0;
        while (fpos < 4 && n < 100) begin
            @(posedge clk);
            #2 n++;
        end
        chk("rstmid_reached", fpos, 4);
        rst = 1;
        #1;
        chk("rstmid_valid", pciValid, 0);
        chk("rstmid_out", pciOut, 0);
        chk("rstmid_tx", txCount, 0);
        chk("rstmid_busy", busy, 0);
        exp_q.delete();
        fpos = 0;
        exp_tx = 0;
        @(posedge clk);
        #2 rst = 0;
        got_q.delete();
        push(32'h0BADF00D, 10'h003, 10'h004);
        wait_idle("after_rst");
        chk("after_rst_len", got_q.size(), 10);
        chk("after_rst_sync", got_q[0], 8'hA5);

        @(posedge clk);
        #2 force dut.r_tx_cnt = 16'hFFFF;
        @(posedge clk);
        #2 release dut.r_tx_cnt;
        chk("wrap_pre", txCount, 16'hFFFF);
        exp_tx = 16'hFFFF;
        push(32'h00C0FFEE, 10'h010, 10'h020);
        wait_idle("wrap");
        chk("wrap_zero", txCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
